// File: rtl/mem_copy_initiator.sv
// mem_copy_initiator
//   Byte-serial copy engine that drives a single-port synchronous byte RAM.
//   It copies Length bytes from SrcAddr to DstAddr, moving forward one byte at a time.
//   Each byte takes a read phase (RD), a capture phase (CAP) and a write phase (WR).
//   While Busy is high the engine owns the RAM port. Arbitration against other
//   masters happens outside this block.
//
//   Optional build macro: MEMCOPY_VERIFY_EN
//     When defined, each write is followed by a read-back (VRD) and a compare (VCMP).
//     A mismatch sets the sticky VerifyErr output.
//
// Ports
//   CLK, RST      clock and asynchronous active-high reset
//   Start         one-cycle request, sampled only while idle
//   SrcAddr       first source address, latched on an accepted Start
//   DstAddr       first destination address, latched on an accepted Start
//   Length        byte count, latched on an accepted Start (0 = no transfer)
//   Busy          high while a transfer is in progress
//   Done          one-cycle completion pulse
//   Count         bytes written so far in the current or last transfer
//   MemWE         RAM write enable
//   MemAddress    RAM address
//   MemDataOut    RAM write data
//   MemDataIn     RAM registered read data, valid the cycle after an address
//   VerifyErr     (MEMCOPY_VERIFY_EN only) sticky read-back mismatch flag
module mem_copy_initiator #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W-1:0] Length,
  output logic              Busy,
  output logic              Done,
  output logic [ADDR_W-1:0] Count,
  output logic              MemWE,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [DATA_W-1:0] MemDataOut,
  input  logic [DATA_W-1:0] MemDataIn
`ifdef MEMCOPY_VERIFY_EN
  ,
  output logic              VerifyErr
`endif
);

`ifdef MEMCOPY_VERIFY_EN
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN, VRD, VCMP} state_t;
`else
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, FIN} state_t;
`endif

  state_t            state;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [ADDR_W-1:0] len;
  logic [DATA_W-1:0] byte_buf;

  logic [ADDR_W-1:0] src_nxt;
  logic [ADDR_W-1:0] dst_nxt;
  logic [ADDR_W-1:0] count_nxt;

  // Pointers wrap naturally at the top of the address space.
  assign src_nxt   = src + ADDR_W'(1);
  assign dst_nxt   = dst + ADDR_W'(1);
  assign count_nxt = Count + ADDR_W'(1);

  // The write data is the captured byte. byte_buf is a register, so this output is registered too.
  assign MemDataOut = byte_buf;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      MemWE      <= 1'b0;
      MemAddress <= '0;
      Count      <= '0;
      src        <= '0;
      dst        <= '0;
      len        <= '0;
      byte_buf   <= '0;
`ifdef MEMCOPY_VERIFY_EN
      VerifyErr  <= 1'b0;
`endif
    end else begin
      // Done and MemWE are pulses. They are only raised for the following state.
      Done  <= 1'b0;
      MemWE <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            Count <= '0;
`ifdef MEMCOPY_VERIFY_EN
            VerifyErr <= 1'b0;
`endif
            if (Length != '0) begin
              src        <= SrcAddr;
              dst        <= DstAddr;
              len        <= Length;
              Busy       <= 1'b1;
              MemAddress <= SrcAddr;
              state      <= RD;
            end else begin
              // A zero-length request completes at once and never touches memory.
              Done  <= 1'b1;
              state <= FIN;
            end
          end
        end
        RD: begin
          // The RAM samples the source address at the end of this cycle.
          state <= CAP;
        end
        CAP: begin
          byte_buf   <= MemDataIn;
          MemAddress <= dst;
          MemWE      <= 1'b1;
          state      <= WR;
        end
`ifdef MEMCOPY_VERIFY_EN
        WR: begin
          // The address stays on dst so the just-written byte can be read back.
          state <= VRD;
        end
        VRD: begin
          state <= VCMP;
        end
        VCMP: begin
          if (MemDataIn != byte_buf) VerifyErr <= 1'b1;
          src   <= src_nxt;
          dst   <= dst_nxt;
          Count <= count_nxt;
          if (count_nxt == len) begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= FIN;
          end else begin
            MemAddress <= src_nxt;
            state      <= RD;
          end
        end
`else
        WR: begin
          src   <= src_nxt;
          dst   <= dst_nxt;
          Count <= count_nxt;
          if (count_nxt == len) begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= FIN;
          end else begin
            MemAddress <= src_nxt;
            state      <= RD;
          end
        end
`endif
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_initiator.sv
// tb_mem_copy_initiator
//   Self-checking bench for mem_copy_initiator.
//   The bench contains a behavioural byte RAM that the DUT drives. A separate
//   reference memory image is updated with a plain forward byte-copy loop.
//   Cycle timing, write count, Count and memory windows are compared against that reference.
//   When MEMCOPY_VERIFY_EN is defined, addresses 0xF000-0xFFFF act as ROM.
module tb_mem_copy_initiator;

`ifdef MEMCOPY_VERIFY_EN
  localparam int CPB = 5;
`else
  localparam int CPB = 3;
`endif

  logic        CLK;
  logic        RST;
  logic        Start;
  logic [15:0] SrcAddr;
  logic [15:0] DstAddr;
  logic [15:0] Length;
  logic        Busy;
  logic        Done;
  logic [15:0] Count;
  logic        MemWE;
  logic [15:0] MemAddress;
  logic [7:0]  MemDataOut;
  logic [7:0]  MemDataIn;
`ifdef MEMCOPY_VERIFY_EN
  logic        VerifyErr;
`endif

  mem_copy_initiator #(.ADDR_W(16), .DATA_W(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Start      (Start),
    .SrcAddr    (SrcAddr),
    .DstAddr    (DstAddr),
    .Length     (Length),
    .Busy       (Busy),
    .Done       (Done),
    .Count      (Count),
    .MemWE      (MemWE),
    .MemAddress (MemAddress),
    .MemDataOut (MemDataOut),
    .MemDataIn  (MemDataIn)
`ifdef MEMCOPY_VERIFY_EN
    ,
    .VerifyErr  (VerifyErr)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural RAM. The bench preload port has priority over DUT writes.
  logic [7:0]  mem     [0:65535];
  logic [7:0]  exp_mem [0:65535];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;

  function automatic logic is_rom(input logic [15:0] a);
    logic r;
    r = (a[15:12] == 4'hF);
`ifndef MEMCOPY_VERIFY_EN
    r = 1'b0;
`endif
    return r;
  endfunction

  always @(posedge CLK) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (MemWE && !is_rom(MemAddress)) mem[MemAddress] <= MemDataOut;
    MemDataIn <= mem[MemAddress];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    @(negedge CLK);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    exp_mem[a] = d;
    @(posedge CLK);
    #1 pl_en = 1'b0;
  endtask

  task automatic poke_rand(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) poke(base + 16'(i), 8'($urandom));
  endtask

  // Reference: forward byte-serial copy with 16-bit wrap. ROM writes are dropped.
  task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input int l);
    logic [15:0] sa, da;
    for (int i = 0; i < l; i++) begin
      sa = s + 16'(i);
      da = d + 16'(i);
      if (!is_rom(da)) exp_mem[da] = exp_mem[sa];
    end
  endtask

  task automatic cmp_window(input string tag, input logic [15:0] base, input int n);
    int diffs;
    logic [15:0] a;
    diffs = 0;
    for (int i = 0; i < n; i++) begin
      a = base + 16'(i);
      if (mem[a] !== exp_mem[a]) diffs++;
    end
    chk(tag, diffs, 0);
  endtask

  // Issues one Start and watches until Done or until the cycle budget runs out.
  // n_done is the sample index of the Done cycle (1 = the cycle after the Start edge), or -1 on timeout.
  // If inject is nonzero, a second Start (Src=Dst=0x0300) is pulsed at that cycle.
  task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                          input int inject, output int n_done, output int n_we,
                          output int busy_seen);
    int n;
    int limit;
    @(negedge CLK);
    Start   = 1'b1;
    SrcAddr = s;
    DstAddr = d;
    Length  = l;
    n = 0;
    n_we = 0;
    busy_seen = 0;
    n_done = -1;
    limit = CPB * int'(l) + 10;
    while (n < limit) begin
      @(negedge CLK);
      n++;
      if (n == inject) begin
        Start   = 1'b1;
        SrcAddr = 16'h0300;
        DstAddr = 16'h0300;
        Length  = 16'd4;
      end else begin
        Start   = 1'b0;
        SrcAddr = 16'($urandom);
        DstAddr = 16'($urandom);
        Length  = 16'($urandom);
      end
      if (MemWE) n_we++;
      if (Busy) busy_seen = 1;
      if (Done) begin
        n_done = n;
        break;
      end
    end
    Start = 1'b0;
  endtask

  int nd, nw, bs;

  initial begin
    Start   = 1'b0;
    SrcAddr = '0;
    DstAddr = '0;
    Length  = '0;
    pl_en   = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    RST     = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_we", MemWE, 0);
    chk("rst_count", Count, 0);
    chk("rst_addr", MemAddress, 0);
    chk("rst_dout", MemDataOut, 0);
`ifdef MEMCOPY_VERIFY_EN
    chk("rst_verr", VerifyErr, 0);
`endif
    RST = 1'b0;

    // Basic 4-byte copy.
    poke_rand(16'h01FE, 8);
    poke(16'h0100, 8'hAA);
    poke(16'h0101, 8'hBB);
    poke(16'h0102, 8'hCC);
    poke(16'h0103, 8'hDD);
    run_copy(16'h0100, 16'h0200, 16'd4, 0, nd, nw, bs);
    model_copy(16'h0100, 16'h0200, 4);
    chk("basic_done_cyc", nd, CPB * 4 + 1);
    chk("basic_we_cnt", nw, 4);
    chk("basic_count", Count, 4);
    chk("basic_b0", mem[16'h0200], 8'hAA);
    chk("basic_b3", mem[16'h0203], 8'hDD);
    cmp_window("basic_win", 16'h01FE, 8);
    @(negedge CLK);
    chk("basic_done_pulse", Done, 0);
    chk("basic_count_hold", Count, 4);

    // Zero length.
    poke(16'h0010, 8'h5C);
    poke(16'h0020, 8'hC5);
    run_copy(16'h0010, 16'h0020, 16'd0, 0, nd, nw, bs);
    chk("len0_done_cyc", nd, 1);
    chk("len0_we_cnt", nw, 0);
    chk("len0_busy", bs, 0);
    cmp_window("len0_win", 16'h0020, 1);
    @(negedge CLK);
    chk("len0_done_pulse", Done, 0);

    // Address wrap combined with forward-overlap propagation.
    poke(16'hFFFE, 8'h11);
    poke(16'hFFFF, 8'h22);
    poke(16'h0000, 8'h33);
    poke(16'h0001, 8'h44);
    poke_rand(16'h0002, 4);
    run_copy(16'hFFFE, 16'h0000, 16'd4, 0, nd, nw, bs);
    model_copy(16'hFFFE, 16'h0000, 4);
    chk("wrap_done_cyc", nd, CPB * 4 + 1);
    chk("wrap_b0", mem[16'h0000], 8'h11);
    chk("wrap_b1", mem[16'h0001], 8'h22);
    chk("wrap_b2", mem[16'h0002], 8'h11);
    chk("wrap_b3", mem[16'h0003], 8'h22);
    cmp_window("wrap_win", 16'hFFFE, 8);

    // A Start pulsed while Busy is ignored.
    poke_rand(16'h0300, 8);
    poke_rand(16'h0400, 4);
    poke_rand(16'h04FE, 8);
    run_copy(16'h0400, 16'h0500, 16'd4, 5, nd, nw, bs);
    model_copy(16'h0400, 16'h0500, 4);
    chk("ign_done_cyc", nd, CPB * 4 + 1);
    chk("ign_we_cnt", nw, 4);
    chk("ign_count", Count, 4);
    cmp_window("ign_dst_win", 16'h04FE, 8);
    cmp_window("ign_0300_win", 16'h0300, 8);
    repeat (3) @(negedge CLK);
    chk("ign_idle_busy", Busy, 0);

    // Reset during the second byte's CAP cycle.
    poke_rand(16'h0600, 4);
    poke_rand(16'h06FE, 8);
    @(negedge CLK);
    Start   = 1'b1;
    SrcAddr = 16'h0600;
    DstAddr = 16'h0700;
    Length  = 16'd4;
    @(negedge CLK);
    Start = 1'b0;
    repeat (CPB + 1) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("rstmid_we", MemWE, 0);
    chk("rstmid_busy", Busy, 0);
    chk("rstmid_done", Done, 0);
    chk("rstmid_count", Count, 0);
    @(negedge CLK);
    RST = 1'b0;
    model_copy(16'h0600, 16'h0700, 1);
    repeat (2) @(negedge CLK);
    chk("rstmid_we_after", MemWE, 0);
    cmp_window("rstmid_win", 16'h06FE, 8);

    // Randomized transfers, including overlaps in both directions and stray Starts.
    for (int it = 0; it < 12; it++) begin
      logic [15:0] s, d;
      int l, inj;
      l = int'($urandom_range(1, 16));
      s = 16'($urandom_range(16'h0800, 16'h7F00));
      if ($urandom_range(0, 1) == 1) d = s + 16'($urandom_range(0, 16)) - 16'd8;
      else d = 16'($urandom_range(16'h0800, 16'h7F00));
      inj = (l >= 3 && $urandom_range(0, 1) == 1) ? int'($urandom_range(2, CPB * l)) : 0;
      poke_rand(s, l);
      poke_rand(d - 16'd2, l + 4);
      run_copy(s, d, 16'(l), inj, nd, nw, bs);
      model_copy(s, d, l);
      chk($sformatf("rnd%0d_done_cyc", it), nd, CPB * l + 1);
      chk($sformatf("rnd%0d_we_cnt", it), nw, l);
      chk($sformatf("rnd%0d_count", it), Count, l);
      cmp_window($sformatf("rnd%0d_dst_win", it), d - 16'd2, l + 4);
      cmp_window($sformatf("rnd%0d_src_win", it), s, l);
`ifdef MEMCOPY_VERIFY_EN
      chk($sformatf("rnd%0d_verr", it), VerifyErr, 0);
`endif
      @(negedge CLK);
      chk($sformatf("rnd%0d_done_pulse", it), Done, 0);
    end

`ifdef MEMCOPY_VERIFY_EN
    // A write into ROM is dropped, so the read-back differs from the copied byte.
    poke(16'hF000, 8'h5A);
    poke(16'hF010, 8'hA5);
    run_copy(16'hF000, 16'hF010, 16'd1, 0, nd, nw, bs);
    model_copy(16'hF000, 16'hF010, 1);
    chk("vfy_done_cyc", nd, 6);
    chk("vfy_err", VerifyErr, 1);
    cmp_window("vfy_rom_win", 16'hF010, 1);
    @(negedge CLK);
    chk("vfy_err_sticky", VerifyErr, 1);
    poke_rand(16'h0900, 1);
    run_copy(16'h0900, 16'h0A00, 16'd1, 0, nd, nw, bs);
    chk("vfy_err_clear", VerifyErr, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
